// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: owns the VRAM write port, merging buffered
// CPU stores with a frame-synchronous full-screen fill engine.
module vram_write_scheduler #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int CELLS      = COLS * ROWS,
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              vsync_pulse,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_data,
  output logic              cpu_ready,
  input  logic              fill_start,
  input  logic [1:0]        fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [1:0]        vram_wdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W + 1)'(CELLS);
  localparam logic [PW:0]       FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [1:0]        fill_col;
  logic              last_q;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  logic              push;
  logic              draining;
  logic              pop;
  logic              bypass;
  logic              store;
  logic              fill_last;
  logic [EW-1:0]     cand;
  logic              in_range;
  logic              cpu_wr;

  assign cpu_ready = (count != FULL_CNT);
  assign push      = cpu_we && cpu_ready;
  assign draining  = (state != FILL);
  assign pop       = draining && (count != '0);
  assign bypass    = draining && (count == '0) && push;
  assign store     = push && !bypass;
  assign fill_last = (state == FILL) && (fill_cnt == LAST_CELL);
  assign cand      = pop ? fifo_mem[rd_ptr] : {cpu_addr, cpu_data};
  assign in_range  = ({1'b0, cand[EW-1:2]} < CELLS_W);
  assign cpu_wr    = (pop || bypass) && in_range;

  // FIFO storage; an empty FIFO is bypassed straight to the port
  always_ff @(posedge sys_clock) begin
    if (store) fifo_mem[wr_ptr] <= {cpu_addr, cpu_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW + 1)'(store) - (PW + 1)'(pop);
    end
  end

  // Fill FSM with busy/done flags aligned to the write port
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      fill_col  <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      last_q    <= fill_last;
      fill_done <= last_q;
      if (last_q) fill_busy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            fill_col  <= fill_color;
            fill_busy <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (vsync_pulse) begin
            fill_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
          if (fill_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered VRAM write port; address and data hold when idle
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else if (state == FILL) begin
      vram_we    <= 1'b1;
      vram_addr  <= fill_cnt;
      vram_wdata <= fill_col;
    end else if (cpu_wr) begin
      vram_we    <= 1'b1;
      vram_addr  <= cand[EW-1:2];
      vram_wdata <= cand[1:0];
    end else begin
      vram_we    <= 1'b0;
    end
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Owns the single write port of the 40x30, 2-bit-per-cell video RAM.
- Arbitrates between CPU store requests, which are buffered in a small FIFO, and a hardware full-screen fill engine that clears the screen to one colour.
- Fill requests are frame-synchronous: a fill runs only after the next vsync_pulse, so the screen is never torn mid-frame.
- Sits between the CPU memory-mapped store path and the VRAM inside the video subsystem.

Parameters:
- COLS, 40, cells per row
- ROWS, 30, rows of cells
- CELLS, COLS*ROWS (1200), total VRAM cells
- ADDR_W, 11, VRAM address width
- FIFO_DEPTH, 4, CPU write FIFO entries; must be a power of 2, >=2

Ports:
- sys_clock  in  1  system clock (100 MHz); all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- vsync_pulse  in  1  one-cycle pulse per frame (frame end)
- cpu_we  in  1  CPU write request
- cpu_addr  in  ADDR_W  cell index, row*COLS+col
- cpu_data  in  2  colour code
- cpu_ready  out  1  high = FIFO can accept; a write is accepted when cpu_we && cpu_ready
- fill_start  in  1  request a full-screen fill
- fill_color  in  2  fill colour, sampled with fill_start
- fill_busy  out  1  fill pending or in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- vram_we  out  1  VRAM write strobe
- vram_addr  out  ADDR_W  VRAM write address
- vram_wdata  out  2  VRAM write data

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, FIFO empty.
  - Outputs: vram_we=0, vram_addr=0, vram_wdata=0, fill_busy=0, fill_done=0, cpu_ready=1.
  - A pending fill is discarded.
- FSM states: IDLE, PEND, FILL.
  - IDLE: fill_start=1 latches fill_color → PEND; fill_busy=1 from the next cycle.
  - PEND: on vsync_pulse=1 → FILL, with fill counter=0.
  - vsync_pulse and fill_start in the same IDLE cycle: go to PEND only; the fill waits for the following vsync_pulse.
  - FILL: one write per cycle, vram_we=1, vram_addr=counter, vram_wdata=latched colour, counter 0..CELLS-1.
  - FILL, after the write with addr CELLS-1 → IDLE. fill_done=1 for one cycle and fill_busy=0 in the cycle after that write.
  - Fill duration: exactly CELLS cycles of vram_we.
  - fill_start while in PEND or FILL: ignored (no re-latch of colour).
- CPU path:
  - Accepted writes enter the FIFO in order.
  - cpu_ready = !full, computed from the registered count. When full, cpu_ready=0 even if a pop occurs in the same cycle.
  - Writes with cpu_addr >= CELLS are accepted, dropped at pop, and never drive vram_we.
  - Simultaneous push and pop with the FIFO not full: count unchanged, both performed.
- Arbitration:
  - In IDLE and PEND, the FIFO head is popped whenever non-empty, one per cycle.
  - A write accepted in cycle N to an empty FIFO appears on vram_we/addr/wdata in cycle N+1 (1-cycle latency).
  - In FILL the FIFO is frozen (no pops; pushes continue until full), so CPU writes issued during a fill land on top of the cleared screen once FILL exits.
  - Draining resumes in the first IDLE cycle after FILL.
- vram_we/addr/wdata are registered outputs. When vram_we=0, addr and wdata hold their last values.

Test Plan:
1. After reset release, write addr 5 colour 2'b11 → vram_we=1, addr=5, wdata=3 exactly one cycle after acceptance; cpu_ready stays 1.
2. cpu_we held with 5 back-to-back writes during FILL → first 4 accepted, cpu_ready=0 on the 5th. After fill_done, 4 writes drained in order on 4 consecutive cycles; the 5th is accepted once cpu_ready returns.
3. fill_start colour 2'b00 in IDLE, vsync_pulse 50 cycles later → fill_busy=1 throughout. 1200 consecutive writes, addr 0..1199, wdata=0. fill_done pulses once; fill_busy=0 afterwards.
4. fill_start in the same cycle as vsync_pulse → no write until the next vsync_pulse, then a full 1200-write fill.
5. Write to addr 1200 and addr 2047 → accepted, no vram_we. A following write to addr 1199 issues normally.
6. reset asserted mid-FILL at counter 600 → vram_we=0 and fill_busy=0 immediately (async), FIFO empty. No further fill after release even on a vsync_pulse.
